shift_mix_stage: RTL and testbench
==================================

SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 SHALL have parameter none; all widths fixed at 128-bit AES state.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port data_in  input  128  SubBytes output state; byte 0 = [127:120], byte k = s[k%4][k/4] (column-major).
REQ-005 SHALL have port i_en  input  1  input valid; transfer when i_en && i_ready.
REQ-006 SHALL have port i_last  input  1  final-round flag, sampled with data_in; skip MixColumns.
REQ-007 SHALL have port i_ready  output  1  stage can accept a word this cycle.
REQ-008 SHALL have port data_out  output  128  ShiftRows(+MixColumns) result, same byte order.
REQ-009 SHALL have port o_valid  output  1  data_out valid; held until consumed.
REQ-010 SHALL have port o_ready  input  1  downstream (AddRoundKey) accepts; transfer when o_valid && o_ready.
REQ-011 SHALL have port o_last  output  1  i_last carried alongside data_out.

Function
REQ-012 ShiftRows SHALL rotate row r left by r byte positions (r=0..3).
REQ-013 MixColumns SHALL multiply each column by circulant {02,03,01,01} over GF(2^8), reduction polynomial 0x11B.
REQ-014 xtime SHALL be ({b[6:0],0}) XOR (0x1B if b[7]); no multipliers, no lookup tables.
REQ-015 i_last=1 word SHALL produce ShiftRows only; i_last=0 word SHALL produce MixColumns(ShiftRows).
REQ-016 Default latency SHALL be 1 cycle: word accepted at edge N appears with o_valid=1 after edge N.
REQ-017 i_ready SHALL equal !o_valid || o_ready (combinational, per pipeline register).
REQ-018 While o_valid=1 and o_ready=0, data_out, o_last, o_valid SHALL hold stable.
REQ-019 Simultaneous output transfer and input accept SHALL replace the word in the same cycle (full throughput, one word/cycle).
REQ-020 Output transfer with no input accept SHALL clear o_valid next cycle.
REQ-021 data_in/i_last SHALL be ignored when i_en=0 or i_ready=0; no word lost or duplicated.
REQ-022 i_last SHALL not affect handshake timing, only data path selection.

Reset
REQ-023 rst=0 SHALL immediately force o_valid=0, o_last=0, data_out=128'h0, all pipeline valid bits 0.
REQ-024 Reset mid-operation SHALL discard in-flight words; no output after release until a new accept.
REQ-025 i_ready SHALL be 1 during and after reset (empty pipeline).
REQ-026 Reset release SHALL be usable on any edge; first accept allowed on first rising edge with rst=1.

Configuration
REQ-027 Macro SHIFT_MIX_PIPE_EN defined: ShiftRows result and last flag registered in stage 1, MixColumns/bypass registered in stage 2; latency 2 cycles; each stage has own valid; stage-1 ready = !v1 || stage-2 ready; throughput still one word/cycle.
REQ-028 Macro SHIFT_MIX_PIPE_EN undefined: single register stage, latency 1 (REQ-016).
REQ-029 Both builds SHALL give identical output sequences; only latency differs; reset behaviour per REQ-023 applies to all stage registers.

Verification
REQ-030 Single word: data_in=d42711aee0bf98f1b8b45de51e415230, i_last=0, o_ready=1 -> data_out=046681e5e0cb199a48f8d37a2806264c, o_valid one cycle (two with SHIFT_MIX_PIPE_EN).
REQ-031 Final round: same data_in, i_last=1 -> data_out=d4bf5d30e0b452aeb84111f11e2798e5, o_last=1.
REQ-032 Column check: data_in=db135345 in column 0 of a state whose rows 1-3 pre-rotated so ShiftRows yields column db135345 -> column 0 out = 8e4da1bc.
REQ-033 Backpressure: stream 4 words, hold o_ready=0 for 5 cycles -> data_out stable, i_ready=0 once full, all 4 words emerge in order after release, none dropped.
REQ-034 Reset mid-stream: assert rst=0 with o_valid=1 -> o_valid=0, data_out=0 immediately; no stale word after release.
REQ-035 Throughput: i_en=1, o_ready=1 for 10 consecutive random words -> 10 consecutive o_valid cycles matching software model, both macro builds.

Source files
------------

// File: rtl/shift_mix_stage.sv
// ---------------------------------------------------------------------------
// shift_mix_stage
//
// One AES round slice placed between SubBytes and AddRoundKey. It applies
// ShiftRows to the incoming 128-bit state and then MixColumns, unless the
// word is flagged as the final round. In that case only ShiftRows is applied.
//
// Byte order: byte 0 is data[127:120]. Byte k is state s[k%4][k/4], so the
// state is column-major and each 32-bit column is contiguous.
//
// Ports
//   clk       : single clock; all state updates happen on the rising edge
//   rst       : asynchronous, active-low reset
//   data_in   : SubBytes output state (128 bits)
//   i_en      : input valid
//   i_last    : final-round flag, travels with data_in
//   i_ready   : stage can accept a word this cycle
//   data_out  : ShiftRows(+MixColumns) result, same byte order
//   o_valid   : data_out valid; held until consumed
//   o_ready   : downstream accepts
//   o_last    : i_last carried alongside data_out
//
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both 1. Valid never depends on ready. While valid is high
// and ready is low, the offered data, last flag and valid stay unchanged.
// Each register stage accepts when it is empty or when it is being drained
// in the same cycle, so the stage sustains one word per cycle.
//
// Configuration macro SHIFT_MIX_PIPE_EN:
//   undefined : one register stage, latency 1
//   defined   : ShiftRows registered in stage 1, MixColumns/bypass in
//               stage 2, latency 2; the output sequence is identical
// ---------------------------------------------------------------------------
module shift_mix_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         i_en,
    input  logic         i_last,
    output logic         i_ready,
    output logic [127:0] data_out,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         o_last
);

    // Multiply by {02} in GF(2^8), reduced modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of the output takes column (c + r) % 4 of the input, which
    // rotates row r left by r byte positions.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return t;
    endfunction

    // Circulant {02,03,01,01}. {03}*a is written as xtime(a) ^ a.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            t[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
        end
        return t;
    endfunction

`ifdef SHIFT_MIX_PIPE_EN

    logic [127:0] sr_q;     // stage 1: ShiftRows result
    logic         last1_q;
    logic         v1_q;
    logic [127:0] out_q;    // stage 2: MixColumns or bypass result
    logic         last2_q;
    logic         v2_q;
    logic         ready2;

    assign ready2  = !v2_q || o_ready;
    assign i_ready = !v1_q || ready2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q    <= '0;
            last1_q <= 1'b0;
            v1_q    <= 1'b0;
        end else if (i_ready) begin
            v1_q <= i_en;
            if (i_en) begin
                sr_q    <= shift_rows(data_in);
                last1_q <= i_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            last2_q <= 1'b0;
            v2_q    <= 1'b0;
        end else if (ready2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                out_q   <= last1_q ? sr_q : mix_columns(sr_q);
                last2_q <= last1_q;
            end
        end
    end

    assign data_out = out_q;
    assign o_last   = last2_q;
    assign o_valid  = v2_q;

`else

    logic [127:0] sr_comb;
    logic [127:0] out_q;
    logic         last_q;
    logic         v_q;

    assign sr_comb = shift_rows(data_in);
    assign i_ready = !v_q || o_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            last_q <= 1'b0;
            v_q    <= 1'b0;
        end else if (i_ready) begin
            v_q <= i_en;
            if (i_en) begin
                out_q  <= i_last ? sr_comb : mix_columns(sr_comb);
                last_q <= i_last;
            end
        end
    end

    assign data_out = out_q;
    assign o_last   = last_q;
    assign o_valid  = v_q;

`endif

endmodule

// File: tb/tb_shift_mix_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_mix_stage
//
// Directed bench for shift_mix_stage. It uses the FIPS-197 round-1 vectors,
// a single-column MixColumns vector, backpressure, reset while a word is in
// flight, and a ten-word back-to-back stream. Expected values for the
// stream come from an independent byte-array reference model in this file.
// ---------------------------------------------------------------------------
module tb_shift_mix_stage;

`ifdef SHIFT_MIX_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [127:0] VA       = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] EXP_MIX  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] EXP_LAST = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] COL_IN   = 128'hdb000000_00130000_00005300_00000045;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc_00000000_00000000_00000000;
    localparam logic [127:0] COL_SR   = 128'hdb135345_00000000_00000000_00000000;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         rst;
    logic [127:0] data_in;
    logic         i_en;
    logic         i_last;
    logic         i_ready;
    logic [127:0] data_out;
    logic         o_valid;
    logic         o_ready;
    logic         o_last;

    int n_pass;
    int n_total;

    logic [128:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    shift_mix_stage dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .i_en     (i_en),
        .i_last   (i_last),
        .i_ready  (i_ready),
        .data_out (data_out),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_last   (o_last)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [128:0] ref_round(input logic [127:0] s, input logic l);
        logic [7:0]   st[4][4];
        logic [7:0]   sr[4][4];
        logic [7:0]   ob;
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = s[127 - 8*(4*c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[r][c] = st[r][(c + r) % 4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (l) ob = sr[r][c];
                else   ob = gf_mul(8'h02, sr[r][c]) ^ gf_mul(8'h03, sr[(r+1)%4][c])
                            ^ sr[(r+2)%4][c] ^ sr[(r+3)%4][c];
                o[127 - 8*(4*c + r) -: 8] = ob;
            end
        end
        return {l, o};
    endfunction

    // ---------------- driver tasks ----------------
    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic push_word(input logic [127:0] d, input logic l, output bit ok);
        ok      = 1'b0;
        data_in = d;
        i_last  = l;
        i_en    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        i_en    = 1'b0;
        i_last  = 1'b0;
        data_in = '0;
    endtask

    // Returns at the falling edge where o_valid is first seen; cyc counts the
    // rising edges since entry, including the one before entry.
    task automatic wait_valid(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_total++; if (o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b want 0", o_valid); else n_pass++;
        n_total++; if (data_out !== 128'h0) $display("FAIL reset_data_out: got %h want 0", data_out); else n_pass++;
        n_total++; if (o_last !== 1'b0) $display("FAIL reset_o_last: got %b want 0", o_last); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (i_ready !== 1'b1) $display("FAIL reset_i_ready: got %b want 1", i_ready); else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mix_round();
        bit ok;
        int cyc;
        o_ready = 1'b1;
        push_word(VA, 1'b0, ok);
        n_total++; if (!ok) $display("FAIL mix_accept: got no accept want accept"); else n_pass++;
        wait_valid(cyc, ok);
        n_total++; if (!ok) $display("FAIL mix_valid: got timeout want o_valid"); else n_pass++;
        n_total++; if (cyc != LAT) $display("FAIL mix_latency: got %0d want %0d", cyc, LAT); else n_pass++;
        n_total++; if (data_out !== EXP_MIX) $display("FAIL mix_data: got %h want %h", data_out, EXP_MIX); else n_pass++;
        n_total++; if (o_last !== 1'b0) $display("FAIL mix_last: got %b want 0", o_last); else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++; if (o_valid !== 1'b0) $display("FAIL mix_valid_clear: got %b want 0", o_valid); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_final_round();
        bit ok;
        int cyc;
        o_ready = 1'b1;
        push_word(VA, 1'b1, ok);
        wait_valid(cyc, ok);
        n_total++; if (!ok || cyc != LAT) $display("FAIL final_latency: got %0d want %0d", cyc, LAT); else n_pass++;
        n_total++; if (data_out !== EXP_LAST) $display("FAIL final_data: got %h want %h", data_out, EXP_LAST); else n_pass++;
        n_total++; if (o_last !== 1'b1) $display("FAIL final_last: got %b want 1", o_last); else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++; if (o_valid !== 1'b0) $display("FAIL final_valid_clear: got %b want 0", o_valid); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_column();
        bit ok;
        int cyc;
        o_ready = 1'b1;
        push_word(COL_IN, 1'b0, ok);
        wait_valid(cyc, ok);
        n_total++; if (!ok) $display("FAIL column_valid: got timeout want o_valid"); else n_pass++;
        n_total++; if (data_out !== COL_OUT) $display("FAIL column_data: got %h want %h", data_out, COL_OUT); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [127:0] in_d[4];
        logic         in_l[4];
        in_d[0] = VA;     in_l[0] = 1'b0;
        in_d[1] = VA;     in_l[1] = 1'b1;
        in_d[2] = COL_IN; in_l[2] = 1'b0;
        in_d[3] = COL_IN; in_l[3] = 1'b1;
        exp_q.delete();
        exp_q.push_back({1'b0, EXP_MIX});
        exp_q.push_back({1'b1, EXP_LAST});
        exp_q.push_back({1'b0, COL_OUT});
        exp_q.push_back({1'b1, COL_SR});
        o_ready = 1'b0;
        fork
            begin
                bit pok;
                for (int i = 0; i < 4; i++) begin
                    push_word(in_d[i], in_l[i], pok);
                    n_total++; if (!pok) $display("FAIL bp_accept_%0d: got no accept want accept", i); else n_pass++;
                end
            end
            begin
                bit           cok;
                int           cyc;
                int           got;
                logic [127:0] held;
                logic [128:0] e;
                wait_valid(cyc, cok);
                n_total++; if (!cok) $display("FAIL bp_first_valid: got timeout want o_valid"); else n_pass++;
                held = data_out;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    n_total++;
                    if (o_valid !== 1'b1 || data_out !== held)
                        $display("FAIL bp_hold_%0d: got v=%b %h want v=1 %h", i, o_valid, data_out, held);
                    else n_pass++;
                end
                n_total++; if (i_ready !== 1'b0) $display("FAIL bp_full_i_ready: got %b want 0", i_ready); else n_pass++;
                @(posedge clk);
                #1;
                o_ready = 1'b1;
                got = 0;
                for (int k = 0; k < 40; k++) begin
                    if (got == 4) break;
                    @(negedge clk);
                    if (o_valid && exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        n_total++;
                        if ({o_last, data_out} !== e)
                            $display("FAIL bp_word_%0d: got %b/%h want %b/%h", got, o_last, data_out, e[128], e[127:0]);
                        else n_pass++;
                        got++;
                    end
                    @(posedge clk);
                    #1;
                end
                n_total++; if (got != 4) $display("FAIL bp_count: got %0d want 4", got); else n_pass++;
            end
        join
    endtask

    task automatic test_reset_mid();
        bit ok;
        int cyc;
        bit stale;
        o_ready = 1'b0;
        push_word(VA, 1'b1, ok);
        wait_valid(cyc, ok);
        n_total++; if (!ok || o_last !== 1'b1) $display("FAIL rmid_setup: got v=%b l=%b want v=1 l=1", o_valid, o_last); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (o_valid !== 1'b0) $display("FAIL rmid_o_valid: got %b want 0", o_valid); else n_pass++;
        n_total++; if (data_out !== 128'h0) $display("FAIL rmid_data_out: got %h want 0", data_out); else n_pass++;
        n_total++; if (o_last !== 1'b0) $display("FAIL rmid_o_last: got %b want 0", o_last); else n_pass++;
        n_total++; if (i_ready !== 1'b1) $display("FAIL rmid_i_ready: got %b want 1", i_ready); else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst     = 1'b1;
        o_ready = 1'b1;
        stale   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) stale = 1'b1;
        end
        n_total++; if (stale) $display("FAIL rmid_stale: got o_valid=1 want 0 after release"); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] w[10];
        logic         l[10];
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            w[i] = {$urandom, $urandom, $urandom, $urandom};
            l[i] = 1'($urandom_range(0, 1));
            exp_q.push_back(ref_round(w[i], l[i]));
        end
        o_ready = 1'b1;
        fork
            begin
                bit rdy_ok;
                rdy_ok = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    i_en    = 1'b1;
                    data_in = w[i];
                    i_last  = l[i];
                    @(negedge clk);
                    if (i_ready !== 1'b1) rdy_ok = 1'b0;
                    @(posedge clk);
                    #1;
                end
                i_en    = 1'b0;
                i_last  = 1'b0;
                data_in = '0;
                n_total++; if (!rdy_ok) $display("FAIL b2b_i_ready: got 0 want 1 every cycle"); else n_pass++;
            end
            begin
                bit           cok;
                int           cyc;
                logic [128:0] e;
                wait_valid(cyc, cok);
                n_total++; if (!cok) $display("FAIL b2b_first_valid: got timeout want o_valid"); else n_pass++;
                for (int i = 0; i < 10; i++) begin
                    if (i > 0) begin
                        @(posedge clk);
                        #1;
                        @(negedge clk);
                    end
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    n_total++;
                    if (o_valid !== 1'b1 || {o_last, data_out} !== e)
                        $display("FAIL b2b_word_%0d: got v=%b %b/%h want v=1 %b/%h", i, o_valid, o_last, data_out, e[128], e[127:0]);
                    else n_pass++;
                end
                @(posedge clk);
                #1;
                @(negedge clk);
                n_total++; if (o_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", o_valid); else n_pass++;
                @(posedge clk);
                #1;
            end
        join
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        i_en    = 1'b0;
        i_last  = 1'b0;
        data_in = '0;
        o_ready = 1'b0;

        test_reset();
        test_mix_round();
        test_final_round();
        test_column();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
